// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//
// Debounces ten raw, active-low board switches/keys that arrive asynchronously
// to i_clk. Each bit is synchronised through two flops and inverted to an
// active-high sample. An independent per-bit counter then requires the sample
// to differ from the accepted level for DEBOUNCE_CYCLES consecutive cycles
// before the new level is accepted. Any single cycle in which the sample
// agrees with the accepted level restarts that bit's count from zero. The
// counter never wraps.
//
// Ports
//   i_clk         in   1   sole clock, rising edge
//   i_reset_n     in   1   asynchronous active-low reset
//   i_switches_n  in  10   raw switches/keys, active-low, asynchronous
//   o_switches    out 10   debounced level, active-high (1 = on/pressed)
//   o_pressed     out 10   one-cycle pulse on a debounced 0->1 change
//   o_released    out 10   one-cycle pulse on a debounced 1->0 change
//
// All outputs come straight from flops. A clean, held pin change shows up on
// o_switches together with its pulse DEBOUNCE_CYCLES+2 edges after it is
// first sampled: two synchroniser edges, DEBOUNCE_CYCLES-1 counting edges and
// the accepting edge.
// -----------------------------------------------------------------------------
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [9:0] i_switches_n,
    output logic [9:0] o_switches,
    output logic [9:0] o_pressed,
    output logic [9:0] o_released
);

    localparam int NUM_KEYS = 10;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Terminal count: the edge that sees this value (with the sample still
    // differing) is the accepting edge.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchroniser stages; they reset to 1 so that reset looks like "released".
    logic [9:0]       sync1_q;
    logic [9:0]       sync2_q;
    logic [9:0]       sample_s;

    logic [CNT_W-1:0] cnt_q [NUM_KEYS];
    logic [CNT_W-1:0] cnt_d [NUM_KEYS];

    logic [9:0]       switches_q;
    logic [9:0]       switches_d;
    logic [9:0]       pressed_q;
    logic [9:0]       pressed_d;
    logic [9:0]       released_q;
    logic [9:0]       released_d;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= 10'h3FF;
            sync2_q <= 10'h3FF;
        end else begin
            sync1_q <= i_switches_n;
            sync2_q <= sync1_q;
        end
    end

    // Active-high synchronised sample.
    assign sample_s = ~sync2_q;

    // Per-bit debounce counters and accepted-level next state.
    always_comb begin
        switches_d = switches_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sample_s[i] == switches_q[i]) begin
                // Agreement, even for one cycle, restarts the count.
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_MAX) begin
                // Stable long enough: accept and restart from zero.
                cnt_d[i]      = CNT_ZERO;
                switches_d[i] = sample_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Edge pulses are derived from the level about to be registered, so the
    // pulse and the new level appear on the same cycle.
    always_comb begin
        pressed_d  = switches_d & ~switches_q;
        released_d = ~switches_d & switches_q;
    end

    // Counter, level and pulse registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            switches_q <= 10'h000;
            pressed_q  <= 10'h000;
            released_q <= 10'h000;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            switches_q <= switches_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign o_switches = switches_q;
    assign o_pressed  = pressed_q;
    assign o_released = released_q;

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for key_debouncer with DEBOUNCE_CYCLES = 4.
// A driver applies one input pattern per cycle (2 ns after the rising edge)
// and pushes the outputs expected after the following edge into a queue; a
// monitor pops one entry 1 ns after every rising edge and compares.
// A clean change first sampled on edge E1 is expected on edge E6.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

    localparam int LAT = 6;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw_n  = 10'h3FF;
    logic [9:0] sw;
    logic [9:0] pr;
    logic [9:0] rl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] e_sw;
        logic [9:0] e_pr;
        logic [9:0] e_rl;
        int         tag;
    } exp_t;

    typedef struct {
        logic [9:0] pin_n;
        int         cycles;
        logic [9:0] final_sw;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[15];

    key_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_switches_n (sw_n),
        .o_switches   (sw),
        .o_pressed    (pr),
        .o_released   (rl)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int tag,
                         input logic [9:0] act, input logic [9:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, tag, act, expv);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic apply(input logic [9:0] pin_n, input logic rst,
                         input logic [9:0] e_sw, input logic [9:0] e_pr,
                         input logic [9:0] e_rl, input int tag);
        @(posedge clk);
        #2;
        sw_n  = pin_n;
        rst_n = rst;
        sb_q.push_back('{e_sw, e_pr, e_rl, tag});
    endtask

    // Monitor: compare outputs against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("o_switches", mon_e.tag, sw, mon_e.e_sw);
            check("o_pressed",  mon_e.tag, pr, mon_e.e_pr);
            check("o_released", mon_e.tag, rl, mon_e.e_rl);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [9:0] cur;
        logic [9:0] esw;
        logic [9:0] epr;
        logic [9:0] erl;
        logic [9:0] pin;

        // Idle after reset, bit 3 press, bit 0 glitches, bit 3 release, 9+0 together.
        vecs[0]  = '{10'h3FF, 20, 10'h000};
        vecs[1]  = '{10'h3F7, 10, 10'h008};
        for (int g = 0; g < 5; g++) begin
            vecs[2 + 2*g] = '{10'h3F6, 3, 10'h008};
            vecs[3 + 2*g] = '{10'h3F7, 3, 10'h008};
        end
        vecs[12] = '{10'h3FF, 10, 10'h000};
        vecs[13] = '{10'h1FE, 10, 10'h201};
        vecs[14] = '{10'h3FF, 10, 10'h000};

        // Reset state with all inputs released.
        for (int c = 0; c < 3; c++) begin
            apply(10'h3FF, 1'b0, 10'h000, 10'h000, 10'h000, 900 + c);
        end

        // Table-driven sequences; a change is due on cycle LAT of its record.
        cur = 10'h000;
        for (int v = 0; v < 15; v++) begin
            for (int c = 1; c <= vecs[v].cycles; c++) begin
                esw = (c < LAT) ? cur : vecs[v].final_sw;
                epr = (c == LAT) ? (vecs[v].final_sw & ~cur) : 10'h000;
                erl = (c == LAT) ? (~vecs[v].final_sw & cur) : 10'h000;
                apply(vecs[v].pin_n, 1'b1, esw, epr, erl, v * 100 + c);
            end
            if (vecs[v].cycles >= LAT) begin
                cur = vecs[v].final_sw;
            end
        end

        // Bit 6 low for exactly 4 cycles: accepted, then released 4 edges later.
        for (int c = 1; c <= 12; c++) begin
            pin = (c <= 4) ? 10'h3BF : 10'h3FF;
            esw = (c >= 6 && c < 10) ? 10'h040 : 10'h000;
            epr = (c == 6) ? 10'h040 : 10'h000;
            erl = (c == 10) ? 10'h040 : 10'h000;
            apply(pin, 1'b1, esw, epr, erl, 2000 + c);
        end

        // Reset 2 cycles into a bit-5 press, input held low through reset.
        for (int c = 1; c <= 2; c++) begin
            apply(10'h3DF, 1'b1, 10'h000, 10'h000, 10'h000, 3000 + c);
        end
        for (int c = 1; c <= 3; c++) begin
            apply(10'h3DF, 1'b0, 10'h000, 10'h000, 10'h000, 3010 + c);
        end
        for (int c = 1; c <= 8; c++) begin
            esw = (c >= LAT) ? 10'h020 : 10'h000;
            epr = (c == LAT) ? 10'h020 : 10'h000;
            apply(10'h3DF, 1'b1, esw, epr, 10'h000, 3020 + c);
        end

        // Reset while bit 5 is on: level drops at once, no release pulse.
        apply(10'h3DF, 1'b0, 10'h000, 10'h000, 10'h000, 3100);
        #1;
        check("async_rst_sw", 3101, sw, 10'h000);
        check("async_rst_rl", 3102, rl, 10'h000);
        for (int c = 1; c <= 2; c++) begin
            apply(10'h3FF, 1'b0, 10'h000, 10'h000, 10'h000, 3110 + c);
        end
        for (int c = 1; c <= 10; c++) begin
            apply(10'h3FF, 1'b1, 10'h000, 10'h000, 10'h000, 3120 + c);
        end

        @(posedge clk);
        @(posedge clk);
        #3;
        check("sb_drain", 4000, 10'(sb_q.size()), 10'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
